stream_downsize: RTL and testbench
==================================

Name: stream_downsize

Overview:
- Wide-to-narrow stream converter; the counterpart of the upsizer.
- Accepts one wide beat of T_DATA_RATIO lanes plus a per-lane keep mask, and emits the kept lanes one per narrow beat, lane 0 first.
- Sits on the transmit side where packed wide words are serialised back onto a narrow stream.
- Packet boundaries are preserved via last.

Parameters:
- T_DATA_WIDTH, 4, width of one lane / one narrow output beat.
- T_DATA_RATIO, 4, lanes per wide input beat; must be >= 2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- s_data_i  input  T_DATA_WIDTH x T_DATA_RATIO (unpacked [T_DATA_RATIO-1:0])  wide beat; lane 0 is sent first.
- s_keep_i  input  T_DATA_RATIO  per-lane valid mask; may be sparse.
- s_last_i  input  1  wide beat ends a packet.
- s_valid_i  input  1  wide beat valid.
- s_ready_o  output  1  wide beat accepted when s_valid_i && s_ready_o.
- m_data_o  output  T_DATA_WIDTH  narrow lane.
- m_last_o  output  1  final narrow beat of the packet.
- m_valid_o  output  1  narrow beat valid.
- m_ready_i  input  1  downstream ready.

Behaviour:
- State:
  - buf_q: lane registers.
  - rem_q: remaining-lane mask, T_DATA_RATIO bits.
  - last_q: last flag of the held beat.
  - Implicit FSM: EMPTY when rem_q==0, DRAIN otherwise.
- Reset (async, rst_n low):
  - rem_q, last_q, buf_q cleared to 0.
  - Outputs: m_valid_o=0, m_last_o=0, m_data_o=0, s_ready_o=1.
  - Reset mid-packet discards the held beat; no partial output follows release.
- Output path:
  - m_valid_o = |rem_q.
  - sel = index of the lowest set bit of rem_q; m_data_o = buf_q[sel].
  - m_last_o = last_q && (rem_q has exactly one bit set).
  - m_* depend only on registers, never on s_*.
- Narrow handshake: on m_valid_o && m_ready_i, clear bit sel of rem_q.
- Input readiness: s_ready_o = (rem_q==0) || (rem_q one-hot && m_ready_i). s_ready_o depends on m_ready_i combinationally; this is the only input-to-output path.
- Load on s_valid_i && s_ready_o:
  - buf_q <= s_data_i, rem_q <= s_keep_i, last_q <= s_last_i.
  - Load overrides the clear when both occur in the same cycle (back-to-back beats).
- Latency and throughput:
  - Beat accepted at edge N: first narrow beat valid in cycle N+1.
  - A beat with K kept lanes drains in K accepted cycles.
  - No idle cycle between consecutive wide beats when m_ready_i stays high.
- Stall: m_ready_i low holds m_data_o, m_last_o and rem_q stable. m_valid_o never drops without a handshake.
- s_keep_i==0:
  - The beat is accepted and produces no output.
  - Its s_last_i is discarded; all-zero keep is an upstream protocol violation.
  - The block never hangs on it.
- Keep with holes (e.g. 4'b1010): lanes 1 then 3 are emitted; lanes 0 and 2 are skipped with no bubble.
- Single-lane last beat (keep one-hot, last=1): m_last_o is asserted on the first and only narrow beat.
- m_last_o is never asserted on a non-final lane.
- Width rules:
  - sel width = $clog2(T_DATA_RATIO).
  - Lowest-set-bit logic is a pure priority encoder, no arithmetic wrap.

Decomposition:
- Package stream_pkg:
  - Function lane_idx_w(ratio) returning $clog2.
  - Function is_onehot(mask).
  - Both are shared with stream_upsize tests.
- One sub-module: stream_lsb_pick (parameter N). Input mask[N-1:0]; outputs idx, any, onehot. Combinational, instantiated once on rem_q.

Test Plan:
1. Full beat, m_ready_i=1: data {D,C,B,A} (lane0=A), keep 4'b1111, last=1 → m_data A,B,C,D on 4 consecutive cycles, m_last_o only with D, s_ready_o high on the D cycle.
2. Back-to-back beats, m_ready_i=1: keep 4'b0011 (last=0) then keep 4'b0111 (last=1) → 5 narrow beats with no gap, m_last_o only on the 5th.
3. Sparse keep 4'b1010, last=1, lanes {4,3,2,1} → outputs 2 then 4 (lanes 1 then 3), m_last_o on 4, two cycles total.
4. Backpressure: m_ready_i toggling 1,0,0,1,... during a full beat → m_data_o and m_last_o stable while stalled; s_ready_o low until the last lane handshakes; every lane emitted once, in order.
5. keep 4'b0000, last=1, followed by keep 4'b0001 → first beat accepted in one cycle with no m_valid_o; second beat emits lane 0 with m_last_o=0.
6. Reset mid-drain: assert rst_n low after 2 of 4 lanes → m_valid_o=0 immediately (async); after release s_ready_o=1 and no stale lanes appear.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared stream helpers: lane index width and one-hot test.
// The upsizer and its tests use the same helpers.
package stream_pkg;

  function automatic int lane_idx_w(input int ratio);
    return (ratio < 2) ? 1 : $clog2(ratio);
  endfunction

  function automatic logic is_onehot(input logic [63:0] mask);
    return (mask != '0) && ((mask & (mask - 64'd1)) == '0);
  endfunction

endpackage

// File: rtl/stream_lsb_pick.sv
// Lowest-set-bit priority encoder over a lane mask.
// Also reports whether any bit is set and whether exactly one is set.
module stream_lsb_pick
  import stream_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]             mask,
  output logic [lane_idx_w(N)-1:0] idx,
  output logic                     any,
  output logic                     onehot
);

  localparam int IW = lane_idx_w(N);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = IW'(i);
      end
    end
  end

  assign any    = |mask;
  assign onehot = is_onehot(64'(mask));

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits the kept lanes of each wide beat
// one per narrow beat, lane 0 first, preserving packet boundaries via last.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 4,
  parameter int T_DATA_RATIO = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO-1:0],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int SelW = lane_idx_w(T_DATA_RATIO);

  logic [T_DATA_WIDTH-1:0] buf_q [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] rem_q;
  logic                    last_q;

  logic [SelW-1:0]         sel;
  logic                    any_rem;
  logic                    one_rem;
  logic [T_DATA_RATIO-1:0] clr_mask;
  logic                    load;
  logic                    drain;

  stream_lsb_pick #(
    .N(T_DATA_RATIO)
  ) u_pick (
    .mask  (rem_q),
    .idx   (sel),
    .any   (any_rem),
    .onehot(one_rem)
  );

  assign m_valid_o = any_rem;
  assign m_data_o  = buf_q[sel];
  assign m_last_o  = last_q && one_rem;

  // A new wide beat can enter while the final held lane leaves.
  assign s_ready_o = !any_rem || (one_rem && m_ready_i);
  assign load      = s_valid_i && s_ready_o;
  assign drain     = any_rem && m_ready_i;

  always_comb begin
    clr_mask      = '0;
    clr_mask[sel] = 1'b1;
  end

  // Load wins over the lane clear so back-to-back beats have no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      last_q <= 1'b0;
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        buf_q[i] <= '0;
      end
    end else if (load) begin
      buf_q  <= s_data_i;
      rem_q  <= s_keep_i;
      last_q <= s_last_i && (|s_keep_i);
    end else if (drain) begin
      rem_q <= rem_q & ~clr_mask;
    end
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Self-checking bench for stream_downsize: table vectors, hand-written
// corner sequences and a randomized run against a lane-queue model.
module tb_stream_downsize;
  import stream_pkg::*;

  localparam int W = 4;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] s_data [R-1:0];
  logic [R-1:0] s_keep;
  logic         s_last;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;

  stream_downsize #(
    .T_DATA_WIDTH(W),
    .T_DATA_RATIO(R)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data_i (s_data),
    .s_keep_i (s_keep),
    .s_last_i (s_last),
    .s_valid_i(s_valid),
    .s_ready_o(s_ready),
    .m_data_o (m_data),
    .m_last_o (m_last),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } narrow_t;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic         rdy;
  } got_t;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  keep;
    logic        last;
    int          exp_n;
    logic [15:0] exp_seq;
    logic [3:0]  exp_lastpos;
  } vec_t;

  int      n_checks = 0;
  int      n_fail = 0;
  int      cyc = 0;
  int      last_fire_cyc = 0;
  narrow_t model_q[$];
  got_t    got_q[$];
  int      got_cyc[$];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_last;
  logic         rand_on = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: narrow handshakes are popped from the model, wide acceptances
  // push their kept lanes in order with last on the highest kept lane.
  always @(negedge clk) begin
    int k;
    narrow_t e;
    cyc++;
    if (!rst_n) begin
      model_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_output("stall_valid", 32'(m_valid), 32'd1);
        check_output("stall_data", 32'(m_data), 32'(prev_data));
        check_output("stall_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready) begin
        got_q.push_back('{m_data, m_last, s_ready});
        got_cyc.push_back(cyc);
        if (model_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_beat: got data %0h, required no beat", m_data);
        end else begin
          e = model_q.pop_front();
          check_output("model_data", 32'(m_data), 32'(e.data));
          check_output("model_last", 32'(m_last), 32'(e.last));
        end
      end
      if (s_valid && s_ready) begin
        last_fire_cyc = cyc;
        k = -1;
        for (int i = 0; i < R; i++) if (s_keep[i]) k = i;
        for (int i = 0; i < R; i++) begin
          if (s_keep[i]) model_q.push_back('{s_data[i], s_last && (i == k)});
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  always @(posedge clk) begin
    if (rand_on) begin
      #1 m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after acceptance.
  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] k, input logic l);
    int t = 0;
    s_valid = 1'b1;
    for (int i = 0; i < R; i++) s_data[i] = d[4*i +: 4];
    s_keep = k;
    s_last = l;
    @(negedge clk);
    while (!s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!s_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: s_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  vec_t vecs[7];
  logic pat[12];

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_keep  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < R; i++) s_data[i] = '0;
    #1;
    check_output("rst_m_valid", 32'(m_valid), 32'd0);
    check_output("rst_m_last", 32'(m_last), 32'd0);
    check_output("rst_m_data", 32'(m_data), 32'd0);
    check_output("rst_s_ready", 32'(s_ready), 32'd1);
    idle(2);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    idle(1);

    vecs[0] = '{16'hDCBA, 4'b1111, 1'b1, 4, 16'hDCBA, 4'b1000};
    vecs[1] = '{16'h4321, 4'b1010, 1'b1, 2, 16'h0042, 4'b0010};
    vecs[2] = '{16'h8765, 4'b0001, 1'b1, 1, 16'h0005, 4'b0001};
    vecs[3] = '{16'h8765, 4'b0100, 1'b0, 1, 16'h0007, 4'b0000};
    vecs[4] = '{16'hFEDC, 4'b0000, 1'b1, 0, 16'h0000, 4'b0000};
    vecs[5] = '{16'h9A5F, 4'b1001, 1'b1, 2, 16'h009F, 4'b0010};
    vecs[6] = '{16'h1234, 4'b0110, 1'b0, 2, 16'h0023, 4'b0000};

    foreach (vecs[v]) begin
      got_q.delete();
      got_cyc.delete();
      apply_stimulus(vecs[v].data, vecs[v].keep, vecs[v].last);
      idle(6);
      check_output($sformatf("vec%0d_count", v), 32'(got_q.size()), 32'(vecs[v].exp_n));
      for (int j = 0; j < vecs[v].exp_n && j < got_q.size(); j++) begin
        check_output($sformatf("vec%0d_data%0d", v, j), 32'(got_q[j].data), 32'(vecs[v].exp_seq[4*j +: 4]));
        check_output($sformatf("vec%0d_last%0d", v, j), 32'(got_q[j].last), 32'(vecs[v].exp_lastpos[j]));
        check_output($sformatf("vec%0d_rdy%0d", v, j), 32'(got_q[j].rdy), 32'(j == vecs[v].exp_n - 1));
        check_output($sformatf("vec%0d_cyc%0d", v, j), 32'(got_cyc[j]), 32'(last_fire_cyc + 1 + j));
      end
    end

    // Back-to-back beats: five narrow beats with no gap, last only on the fifth.
    got_q.delete();
    got_cyc.delete();
    apply_stimulus(16'h0021, 4'b0011, 1'b0);
    apply_stimulus(16'h0543, 4'b0111, 1'b1);
    idle(8);
    check_output("b2b_count", 32'(got_q.size()), 32'd5);
    for (int j = 0; j < 5 && j < got_q.size(); j++) begin
      check_output($sformatf("b2b_data%0d", j), 32'(got_q[j].data), 32'(j + 1));
      check_output($sformatf("b2b_last%0d", j), 32'(got_q[j].last), 32'(j == 4));
      check_output($sformatf("b2b_cyc%0d", j), 32'(got_cyc[j]), 32'(got_cyc[0] + j));
    end

    // Empty keep is swallowed; the following single-lane beat is not last.
    got_q.delete();
    apply_stimulus(16'h0000, 4'b0000, 1'b1);
    apply_stimulus(16'h0007, 4'b0001, 1'b0);
    idle(4);
    check_output("keep0_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      check_output("keep0_data", 32'(got_q[0].data), 32'd7);
      check_output("keep0_last", 32'(got_q[0].last), 32'd0);
    end

    // Backpressure: ready toggles; the second beat enters only as D leaves.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    got_q.delete();
    got_cyc.delete();
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          m_ready = pat[i];
          @(posedge clk);
          #1;
        end
        m_ready = 1'b1;
      end
      begin
        apply_stimulus(16'hDCBA, 4'b1111, 1'b1);
        apply_stimulus(16'h0065, 4'b0011, 1'b1);
      end
    join
    m_ready = 1'b1;
    idle(8);
    check_output("bp_count", 32'(got_q.size()), 32'd6);
    if (got_q.size() == 6) begin
      check_output("bp_data0", 32'(got_q[0].data), 32'hA);
      check_output("bp_data3", 32'(got_q[3].data), 32'hD);
      check_output("bp_last3", 32'(got_q[3].last), 32'd1);
      check_output("bp_data5", 32'(got_q[5].data), 32'h6);
      check_output("bp_last5", 32'(got_q[5].last), 32'd1);
      check_output("bp_fire_at_d", 32'(last_fire_cyc), 32'(got_cyc[3]));
    end

    // Reset mid-drain after two lanes: outputs drop at once, nothing stale after.
    apply_stimulus(16'hDCBA, 4'b1111, 1'b1);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_m_valid", 32'(m_valid), 32'd0);
    check_output("midrst_m_last", 32'(m_last), 32'd0);
    check_output("midrst_s_ready", 32'(s_ready), 32'd1);
    idle(2);
    rst_n = 1'b1;
    got_q.delete();
    idle(6);
    check_output("midrst_no_stale", 32'(got_q.size()), 32'd0);
    check_output("midrst_ready_after", 32'(s_ready), 32'd1);

    // Randomized traffic with random downstream stalls.
    rand_on = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      apply_stimulus(16'($urandom), 4'($urandom), 1'($urandom));
    end
    rand_on = 1'b0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    idle(10);
    check_output("rand_drained", 32'(model_q.size()), 32'd0);
    check_output("rand_idle_valid", 32'(m_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
